// File: rtl/sdram_seq_pkg.sv
// -----------------------------------------------------------------------------
// sdram_seq_pkg
// Shared definitions for the SDRAM frame-buffer request sequencer:
//   - seq_state_t : request FSM encoding (IDLE / WR_REQ / RD_REQ)
//   - *_DEF       : default address-field geometry of the frame buffer
//   - FRAMES_W    : width of the completed-frame counter
// -----------------------------------------------------------------------------
package sdram_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_REQ = 2'd1,
      RD_REQ = 2'd2
   } seq_state_t;

   localparam int ADDR_W_DEF  = 24;
   localparam int ROW_LSB_DEF = 9;
   localparam int ROW_W_DEF   = 13;
   localparam int BUF_BIT_DEF = 22;
   localparam int FRAMES_W    = 8;

endpackage

// File: rtl/sdram_frame_seq_if.sv
// -----------------------------------------------------------------------------
// sdram_frame_seq_if
// Request/ack bus between the frame sequencer and sdram_top.
//   wr_sdram_req / wr_sdram_add : write burst request and row address
//   wr_sdram_ack                : write burst complete, 1-cycle pulse
//   rd_sdram_req / rd_sdram_add : read burst request and row address
//   rd_sdram_ack                : read burst complete, 1-cycle pulse
// Modports: master = sequencer side, slave = sdram_top side.
// -----------------------------------------------------------------------------
interface sdram_frame_seq_if
   import sdram_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic              wr_sdram_req;
   logic              wr_sdram_ack;
   logic [ADDR_W-1:0] wr_sdram_add;
   logic              rd_sdram_req;
   logic              rd_sdram_ack;
   logic [ADDR_W-1:0] rd_sdram_add;

   modport master (
      output wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add,
      input  wr_sdram_ack, rd_sdram_ack
   );

   modport slave (
      input  wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add,
      output wr_sdram_ack, rd_sdram_ack
   );

endinterface

// File: rtl/sdram_frame_seq_vsync_sync_edge.sv
// -----------------------------------------------------------------------------
// vsync_sync_edge
// Brings the asynchronous VGA vsync into the SDRAM clock domain.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_async        : asynchronous level input
//   o_level        : 2-FF synchronised level
//   o_fall         : registered 1-cycle pulse on the synchronised falling edge
//                    (high during the cycle after the 3rd clock edge that
//                    follows the input fall)
// -----------------------------------------------------------------------------
module vsync_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;
   logic r_fall;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_sync_d <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_meta   <= i_async;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
         r_fall   <= r_sync_d & ~r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_fall  = r_fall;

endmodule

// File: rtl/sdram_frame_seq.sv
// -----------------------------------------------------------------------------
// sdram_frame_seq
// Arbitrates row-burst writes (ROM->FIFO->SDRAM) and row-burst reads
// (SDRAM->VGA FIFO) onto the single sdram_top request/ack pair. Reads win
// ties, one request outstanding at a time, read frame restarts on vsync low.
// Ports:
//   clk_133M, rst_133     : clock, asynchronous active-low reset
//   vsync_i               : raw VGA vsync (low = blanking)
//   wr_fifo_used          : write-FIFO fill level
//   rd_fifo_used          : read-FIFO fill level
//   fifo_clear            : 1-cycle pulse on synchronised vsync fall
//   frame_ready           : sticky, at least one full frame in SDRAM
//   frames_written        : completed-frame counter
//   bus (master)          : request/ack/address bus to sdram_top
// Build option: define PINGPONG_EN for double buffering; otherwise a single
// buffer is written once and then only read.
// -----------------------------------------------------------------------------
module sdram_frame_seq
   import sdram_seq_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int ROW_LSB   = ROW_LSB_DEF,
   parameter int ROW_W     = ROW_W_DEF,
   parameter int BUF_BIT   = BUF_BIT_DEF,
   parameter int NUM_ROWS  = 128,
   parameter int CNT_W     = 11,
   parameter int WR_THRESH = 512,
   parameter int RD_THRESH = 512
) (
   input  logic                clk_133M,
   input  logic                rst_133,
   input  logic                vsync_i,
   input  logic [CNT_W-1:0]    wr_fifo_used,
   input  logic [CNT_W-1:0]    rd_fifo_used,
   output logic                fifo_clear,
   output logic                frame_ready,
   output logic [FRAMES_W-1:0] frames_written,
   sdram_frame_seq_if.master   bus
);

   // Row counters must be able to hold NUM_ROWS itself ("frame done").
   localparam int W_ROW = $clog2(NUM_ROWS + 1);
   localparam logic [W_ROW-1:0] LP_NROWS = W_ROW'(NUM_ROWS);
   localparam logic [W_ROW-1:0] LP_LAST  = W_ROW'(NUM_ROWS - 1);
   localparam logic [CNT_W-1:0] LP_WR_TH = CNT_W'(WR_THRESH);
   localparam logic [CNT_W-1:0] LP_RD_TH = CNT_W'(RD_THRESH);

   seq_state_t          r_state;
   seq_state_t          w_state_nxt;
   logic [W_ROW-1:0]    r_wr_row;
   logic [W_ROW-1:0]    r_rd_row;
   logic                r_wr_buf;
   logic                r_rd_buf;
   logic                r_last_buf;
   logic                r_frame_ready;
   logic [FRAMES_W-1:0] r_frames_written;
   logic [ADDR_W-1:0]   r_wr_add;
   logic [ADDR_W-1:0]   r_rd_add;

   logic w_vs_sync;
   logic w_rd_elig;
   logic w_wr_elig;
   logic w_wr_stall;
   logic w_issue_wr;
   logic w_issue_rd;
   logic w_wr_done;
   logic w_rd_done;
   logic w_frame_done;

   function automatic logic [ADDR_W-1:0] f_addr(input logic [W_ROW-1:0] row,
                                                input logic buf_sel);
      logic [ADDR_W-1:0] a;
      a = '0;
      a[ROW_LSB +: ROW_W] = ROW_W'(row);
      a[BUF_BIT] = buf_sel;
      return a;
   endfunction

   vsync_sync_edge u_vsync (
      .i_clk   (clk_133M),
      .i_rst_n (rst_133),
      .i_async (vsync_i),
      .o_level (w_vs_sync),
      .o_fall  (fifo_clear)
   );

`ifdef PINGPONG_EN
   // Writer waits at row 0 of the buffer the reader is still scanning.
   // Before the first frame exists the reader is idle, so no stall then.
   assign w_wr_stall = r_frame_ready & (r_wr_row == '0) & (r_wr_buf == r_rd_buf)
                     & w_vs_sync & (r_rd_row < LP_NROWS);
`else
   assign w_wr_stall = 1'b0;
`endif

   assign w_rd_elig = r_frame_ready & w_vs_sync & (r_rd_row < LP_NROWS)
                    & (rd_fifo_used <= LP_RD_TH);
   assign w_wr_elig = (r_wr_row < LP_NROWS) & (wr_fifo_used >= LP_WR_TH) & ~w_wr_stall;

   // Acks only count against the matching outstanding request.
   assign w_wr_done    = (r_state == WR_REQ) & bus.wr_sdram_ack;
   assign w_rd_done    = (r_state == RD_REQ) & bus.rd_sdram_ack;
   assign w_frame_done = w_wr_done & (r_wr_row == LP_LAST);

   always_ff @(posedge clk_133M or negedge rst_133) begin
      if (!rst_133) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue_wr  = 1'b0;
      w_issue_rd  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rd_elig) begin
               w_state_nxt = RD_REQ;
               w_issue_rd  = 1'b1;
            end else if (w_wr_elig) begin
               w_state_nxt = WR_REQ;
               w_issue_wr  = 1'b1;
            end
         end
         WR_REQ:  if (bus.wr_sdram_ack) w_state_nxt = IDLE;
         RD_REQ:  if (bus.rd_sdram_ack) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_133M or negedge rst_133) begin
      if (!rst_133) begin
         r_wr_row         <= '0;
         r_rd_row         <= '0;
         r_wr_buf         <= 1'b0;
         r_rd_buf         <= 1'b0;
         r_last_buf       <= 1'b0;
         r_frame_ready    <= 1'b0;
         r_frames_written <= '0;
         r_wr_add         <= '0;
         r_rd_add         <= '0;
      end else begin
         // Addresses are latched at issue so they stay put while req is high.
         if (w_issue_wr) r_wr_add <= f_addr(r_wr_row, r_wr_buf);
         if (w_issue_rd) r_rd_add <= f_addr(r_rd_row, r_rd_buf);

         if (w_wr_done) begin
`ifdef PINGPONG_EN
            r_wr_row <= w_frame_done ? '0 : r_wr_row + W_ROW'(1);
`else
            r_wr_row <= r_wr_row + W_ROW'(1);
`endif
         end

         if (w_frame_done) begin
            r_frame_ready <= 1'b1;
            r_last_buf    <= r_wr_buf;
`ifdef PINGPONG_EN
            r_wr_buf         <= ~r_wr_buf;
            r_frames_written <= r_frames_written + FRAMES_W'(1);
`else
            if (r_frames_written == '0) r_frames_written <= FRAMES_W'(1);
`endif
         end

         // A read finishing during blanking starts the next frame at row 0.
         if (w_rd_done)
            r_rd_row <= w_vs_sync ? r_rd_row + W_ROW'(1) : '0;
         else if (!w_vs_sync && (r_state != RD_REQ))
            r_rd_row <= '0;

         // A frame completing on the clear cycle is the freshest buffer.
         if (fifo_clear)
            r_rd_buf <= w_frame_done ? r_wr_buf : r_last_buf;
      end
   end

   assign bus.wr_sdram_req = (r_state == WR_REQ);
   assign bus.rd_sdram_req = (r_state == RD_REQ);
   assign bus.wr_sdram_add = r_wr_add;
   assign bus.rd_sdram_add = r_rd_add;
   assign frame_ready      = r_frame_ready;
   assign frames_written   = r_frames_written;

endmodule

// File: tb/tb_sdram_frame_seq.sv
`timescale 1ns/1ps
module tb_sdram_frame_seq;
   import sdram_seq_pkg::*;

   localparam int ADDR_W   = 24;
   localparam int ROW_LSB  = 9;
   localparam int ROW_W    = 13;
   localparam int BUF_BIT  = 22;
   localparam int NUM_ROWS = 4;
   localparam int CNT_W    = 11;
`ifdef PINGPONG_EN
   localparam int S4_ROW   = 2;
`else
   localparam int S4_ROW   = 1;
`endif

   logic             clk_133M = 1'b0;
   logic             rst_133  = 1'b0;
   logic             vsync_i  = 1'b1;
   logic [CNT_W-1:0] wr_fifo_used = '0;
   logic [CNT_W-1:0] rd_fifo_used = '0;
   logic             fifo_clear;
   logic             frame_ready;
   logic [7:0]       frames_written;

   int n_cmp = 0;
   int n_err = 0;

   sdram_frame_seq_if #(.ADDR_W(ADDR_W)) bus ();

   sdram_frame_seq #(
      .ADDR_W(ADDR_W), .ROW_LSB(ROW_LSB), .ROW_W(ROW_W), .BUF_BIT(BUF_BIT),
      .NUM_ROWS(NUM_ROWS), .CNT_W(CNT_W), .WR_THRESH(512), .RD_THRESH(512)
   ) dut (
      .clk_133M       (clk_133M),
      .rst_133        (rst_133),
      .vsync_i        (vsync_i),
      .wr_fifo_used   (wr_fifo_used),
      .rd_fifo_used   (rd_fifo_used),
      .fifo_clear     (fifo_clear),
      .frame_ready    (frame_ready),
      .frames_written (frames_written),
      .bus            (bus)
   );

   always #4 clk_133M = ~clk_133M;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_133M);
      @(negedge clk_133M);
   endtask

   function automatic logic [31:0] exp_addr(input int row, input int b);
      return (32'(row) << ROW_LSB) | (32'(b) << BUF_BIT);
   endfunction

   task automatic wait_wr(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.wr_sdram_req) begin seen = 1'b1; break; end
         tick();
      end
   endtask

   task automatic wait_rd(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.rd_sdram_req) begin seen = 1'b1; break; end
         tick();
      end
   endtask

   task automatic wr_burst(input int row, input int b, input string tag);
      bit seen;
      wait_wr(seen);
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, "_add"}, 32'(bus.wr_sdram_add), exp_addr(row, b));
         chk({tag, "_rd_quiet"}, 32'(bus.rd_sdram_req), 32'd0);
         tick();
         chk({tag, "_held"}, 32'(bus.wr_sdram_req), 32'd1);
         bus.wr_sdram_ack = 1'b1;
         tick();
         bus.wr_sdram_ack = 1'b0;
         chk({tag, "_drop"}, 32'(bus.wr_sdram_req), 32'd0);
      end
   endtask

   task automatic rd_burst(input int row, input int b, input string tag);
      bit seen;
      wait_rd(seen);
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, "_add"}, 32'(bus.rd_sdram_add), exp_addr(row, b));
         chk({tag, "_wr_quiet"}, 32'(bus.wr_sdram_req), 32'd0);
         tick();
         chk({tag, "_held"}, 32'(bus.rd_sdram_req), 32'd1);
         bus.rd_sdram_ack = 1'b1;
         tick();
         bus.rd_sdram_ack = 1'b0;
         chk({tag, "_drop"}, 32'(bus.rd_sdram_req), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit seen;
      bus.wr_sdram_ack = 1'b0;
      bus.rd_sdram_ack = 1'b0;
      rd_fifo_used     = 11'd1000;
      repeat (3) @(negedge clk_133M);

      // Reset state
      chk("rst_wr_req", 32'(bus.wr_sdram_req), 32'd0);
      chk("rst_rd_req", 32'(bus.rd_sdram_req), 32'd0);
      chk("rst_wr_add", 32'(bus.wr_sdram_add), 32'd0);
      chk("rst_rd_add", 32'(bus.rd_sdram_add), 32'd0);
      chk("rst_fifo_clear", 32'(fifo_clear), 32'd0);
      chk("rst_frame_ready", 32'(frame_ready), 32'd0);
      chk("rst_frames", 32'(frames_written), 32'd0);
      rst_133 = 1'b1;
      tick();
      tick();

      // First frame: rows 0..3 into buffer 0, no reads
      wr_fifo_used = 11'd600;
      for (int r = 0; r < NUM_ROWS; r++) begin
         wr_burst(r, 0, "s1_wr");
         if (r < NUM_ROWS - 1) chk("s1_fr_early", 32'(frame_ready), 32'd0);
      end
      chk("s1_frame_ready", 32'(frame_ready), 32'd1);
      chk("s1_frames", 32'(frames_written), 32'd1);
`ifdef PINGPONG_EN
      wr_fifo_used = 11'd0;
`else
      n = 0;
      repeat (10) begin tick(); n += int'(bus.wr_sdram_req); end
      chk("s6_no_more_wr", 32'(n), 32'd0);
      chk("s6_frames_hold", 32'(frames_written), 32'd1);
`endif

      // Read threshold: 513 blocks, 512 issues on the next IDLE cycle
      rd_fifo_used = 11'd513;
      n = 0;
      repeat (6) begin tick(); n += int'(bus.rd_sdram_req); end
      chk("s3_rd_block_513", 32'(n), 32'd0);
      rd_fifo_used = 11'd512;
      tick();
      chk("s3_rd_req_512", 32'(bus.rd_sdram_req), 32'd1);
      rd_burst(0, 0, "s3_rd");
      rd_fifo_used = 11'd1000;

`ifdef PINGPONG_EN
      // Read wins the tie; write follows after one IDLE cycle
      rd_fifo_used = 11'd100;
      wr_fifo_used = 11'd600;
      tick();
      chk("s2_rd_first", 32'(bus.rd_sdram_req), 32'd1);
      chk("s2_wr_waits", 32'(bus.wr_sdram_req), 32'd0);
      chk("s2_rd_add", 32'(bus.rd_sdram_add), exp_addr(1, 0));
      tick();
      bus.rd_sdram_ack = 1'b1;
      tick();
      bus.rd_sdram_ack = 1'b0;
      rd_fifo_used = 11'd1000;
      chk("s2_idle_rd", 32'(bus.rd_sdram_req), 32'd0);
      chk("s2_idle_wr", 32'(bus.wr_sdram_req), 32'd0);
      tick();
      chk("s2_wr_after", 32'(bus.wr_sdram_req), 32'd1);
      chk("s2_wr_add", 32'(bus.wr_sdram_add), exp_addr(0, 1));
      wr_fifo_used = 11'd0;
      tick();
      bus.wr_sdram_ack = 1'b1;
      tick();
      bus.wr_sdram_ack = 1'b0;
      chk("s2_wr_drop", 32'(bus.wr_sdram_req), 32'd0);
`endif

      // vsync falls mid-read: request kept, row restarts, one clear pulse
      rd_fifo_used = 11'd512;
      wait_rd(seen);
      chk("s4_rd_seen", 32'(seen), 32'd1);
      chk("s4_rd_add", 32'(bus.rd_sdram_add), exp_addr(S4_ROW, 0));
      rd_fifo_used = 11'd1000;
      vsync_i = 1'b0;
      tick();
      chk("s4_fc_e1", 32'(fifo_clear), 32'd0);
      chk("s4_rd_held_e1", 32'(bus.rd_sdram_req), 32'd1);
      tick();
      chk("s4_fc_e2", 32'(fifo_clear), 32'd0);
      tick();
      chk("s4_fc_e3", 32'(fifo_clear), 32'd1);
      chk("s4_rd_held_e3", 32'(bus.rd_sdram_req), 32'd1);
      tick();
      chk("s4_fc_e4", 32'(fifo_clear), 32'd0);
      bus.rd_sdram_ack = 1'b1;
      tick();
      bus.rd_sdram_ack = 1'b0;
      chk("s4_rd_drop", 32'(bus.rd_sdram_req), 32'd0);
      n = 0;
      repeat (4) begin tick(); n += int'(fifo_clear) + int'(bus.rd_sdram_req); end
      chk("s4_quiet_blank", 32'(n), 32'd0);
      vsync_i = 1'b1;
      rd_fifo_used = 11'd512;
      rd_burst(0, 0, "s4_restart");
      rd_fifo_used = 11'd1000;

`ifdef PINGPONG_EN
      // Writer finishes buffer 1 while reads sit on buffer 0, then stalls
      wr_fifo_used = 11'd600;
      for (int r = 1; r < NUM_ROWS; r++) wr_burst(r, 1, "s5_wr_b1");
      chk("s5_frames2", 32'(frames_written), 32'd2);
      n = 0;
      repeat (8) begin tick(); n += int'(bus.wr_sdram_req); end
      chk("s5_stall", 32'(n), 32'd0);
      rd_fifo_used = 11'd100;
      for (int r = 1; r < NUM_ROWS; r++) rd_burst(r, 0, "s5_rd_b0");
      rd_fifo_used = 11'd1000;
      wr_burst(0, 0, "s5_wr_resume");
      chk("s5_frames_after", 32'(frames_written), 32'd2);
`else
      chk("s6_frames_end", 32'(frames_written), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
